// File: rtl/multi_led_blinker_pkg.sv
// multi_led_blinker_pkg
// Shared definitions for the multi-LED blinker:
//   mode_e      - display mode encoding (SINGLE / ALL / CHASE)
//   chan_width  - bit width of the channel index for a given LED count
//   lfsr_taps   - maximal-length tap mask for a Fibonacci XNOR LFSR, widths 3..32
package multi_led_blinker_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_ALL    = 2'd1,
        MODE_CHASE  = 2'd2
    } mode_e;

    function automatic int chan_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Bit k-1 set for tap k (1-based tap numbering of the classic XNOR tap table).
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] t;
        case (width)
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/multi_led_blinker_debounce.sv
// switch_debounce
// Two-flop synchroniser followed by a stability filter for one raw push-button.
//   i_Clk     - system clock
//   i_Rst_L   - synchronous active-low reset
//   i_Switch  - raw (asynchronous, bouncy) switch level
//   o_Switch  - debounced level
//   o_Release - one-cycle pulse, registered, when the debounced level falls 1->0
module switch_debounce #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Release
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             meta_q, sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             rel_q, rel_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any agreeing sample restarts the qualification window.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync_q != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rel_d = lvl_q & ~lvl_d;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rel_q  <= 1'b0;
        end else begin
            meta_q <= i_Switch;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rel_q  <= rel_d;
        end
    end

    assign o_Switch  = lvl_q;
    assign o_Release = rel_q;

endmodule

// File: rtl/multi_led_blinker.sv
// multi_led_blinker
// Drives NUM_LEDS LEDs from an LFSR-paced blink tick; two debounced buttons
// step the active channel and the display mode (SINGLE, ALL, CHASE).
//   i_Clk      - system clock
//   i_Rst_L    - synchronous active-low reset
//   i_Switch_1 - raw button, steps channel on release (SINGLE/ALL only)
//   i_Switch_2 - raw button, steps mode on release
//   o_LED      - registered LED drive, 1 = on
//   o_Channel  - current channel index
//   o_Mode     - current mode (0 SINGLE, 1 ALL, 2 CHASE)
module multi_led_blinker
    import multi_led_blinker_pkg::*;
#(
    parameter int NUM_LEDS       = 4,
    parameter int LFSR_WIDTH     = 22,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst_L,
    input  logic                            i_Switch_1,
    input  logic                            i_Switch_2,
    output logic [NUM_LEDS-1:0]             o_LED,
    output logic [chan_width(NUM_LEDS)-1:0] o_Channel,
    output logic [1:0]                      o_Mode
);

    localparam int                    CW       = chan_width(NUM_LEDS);
    localparam logic [31:0]           TAPS_ALL = lfsr_taps(LFSR_WIDTH);
    localparam logic [LFSR_WIDTH-1:0] TAPS     = TAPS_ALL[LFSR_WIDTH-1:0];
    localparam logic [CW-1:0]         LAST_CH  = CW'(NUM_LEDS - 1);

    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic                  tick;
    logic                  rel1, rel2;
    logic [1:0]            sw_level_unused;
    mode_e                 mode_q, mode_d;
    logic [CW-1:0]         chan_q, chan_d, chan_inc;
    logic                  tog_q, tog_d;
    logic [NUM_LEDS-1:0]   led_q, led_d;

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw1 (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Switch  (i_Switch_1),
        .o_Switch  (sw_level_unused[0]),
        .o_Release (rel1)
    );

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw2 (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Switch  (i_Switch_2),
        .o_Switch  (sw_level_unused[1]),
        .o_Release (rel2)
    );

    // XNOR feedback makes all-zeros a legal start state; the tick marks the
    // cycle in which the register is about to come back round to all-zeros.
    assign lfsr_d   = {lfsr_q[LFSR_WIDTH-2:0], ~^(lfsr_q & TAPS)};
    assign tick     = (lfsr_d == '0);
    assign chan_inc = (chan_q == LAST_CH) ? '0 : chan_q + CW'(1);

    always_comb begin
        mode_d = mode_q;
        chan_d = chan_q;
        tog_d  = tog_q;
        // Decisions use the current mode, so a tick landing on the switch
        // into CHASE does not advance, and Switch_1 sees the old mode.
        if (tick) begin
            tog_d = ~tog_q;
            if (mode_q == MODE_CHASE) chan_d = chan_inc;
        end
        if (rel1 && mode_q != MODE_CHASE) chan_d = chan_inc;
        if (rel2) begin
            tog_d = 1'b0;
            case (mode_q)
                MODE_SINGLE: mode_d = MODE_ALL;
                MODE_ALL:    mode_d = MODE_CHASE;
                default:     mode_d = MODE_SINGLE;
            endcase
        end

        led_d = '0;
        case (mode_q)
            MODE_ALL:   led_d = {NUM_LEDS{tog_q}};
            MODE_CHASE: led_d[chan_q] = 1'b1;
            default:    led_d[chan_q] = tog_q;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            lfsr_q <= '0;
            tog_q  <= 1'b0;
            chan_q <= '0;
            mode_q <= MODE_SINGLE;
            led_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            tog_q  <= tog_d;
            chan_q <= chan_d;
            mode_q <= mode_d;
            led_q  <= led_d;
        end
    end

    assign o_LED     = led_q;
    assign o_Channel = chan_q;
    assign o_Mode    = mode_q;

endmodule

// File: tb/tb_multi_led_blinker.sv
// Bench for multi_led_blinker with NUM_LEDS=4, LFSR_WIDTH=4, DEBOUNCE_LIMIT=4.
// A cycle-level reference model tracks tick timing by counting clocks,
// accepts a switch level after DEBOUNCE_LIMIT agreeing synchronised samples,
// and applies the mode/channel/toggle rules with plain arithmetic.
module tb_multi_led_blinker;

    localparam int NL     = 4;
    localparam int LW     = 4;
    localparam int DL     = 4;
    localparam int PERIOD = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          sw1 = 1'b0;
    logic          sw2 = 1'b0;
    logic [NL-1:0] led;
    logic [1:0]    chan;
    logic [1:0]    mode;

    multi_led_blinker #(
        .NUM_LEDS       (NL),
        .LFSR_WIDTH     (LW),
        .DEBOUNCE_LIMIT (DL)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_l),
        .i_Switch_1 (sw1),
        .i_Switch_2 (sw2),
        .o_LED      (led),
        .o_Channel  (chan),
        .o_Mode     (mode)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_mode = 0;
    int m_chan = 0;
    int m_tog  = 0;
    int m_led  = 0;
    int ecnt   = 0;
    bit lvl[2];
    bit relp[2];
    bit hist[2][$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit raw[2];
        int nm, nc, nt;
        bit flip;
        raw[0] = sw1;
        raw[1] = sw2;
        if (!rst_l) begin
            m_mode = 0; m_chan = 0; m_tog = 0; m_led = 0; ecnt = 0;
            for (int s = 0; s < 2; s++) begin
                lvl[s]  = 1'b0;
                relp[s] = 1'b0;
                hist[s].delete();
                repeat (DL + 2) hist[s].push_back(1'b0);
            end
        end else begin
            ecnt++;
            // LEDs show the state held before this edge
            if (m_mode == 1)      m_led = m_tog ? (1 << NL) - 1 : 0;
            else if (m_mode == 2) m_led = 1 << m_chan;
            else                  m_led = m_tog ? (1 << m_chan) : 0;
            nm = m_mode; nc = m_chan; nt = m_tog;
            if (ecnt % PERIOD == 0) begin
                nt = 1 - m_tog;
                if (m_mode == 2) nc = (m_chan + 1) % NL;
            end
            if (relp[0] && m_mode != 2) nc = (m_chan + 1) % NL;
            if (relp[1]) begin
                nm = (m_mode + 1) % 3;
                nt = 0;
            end
            m_mode = nm; m_chan = nc; m_tog = nt;
            // level accepted once DL consecutive samples, seen two clocks late, disagree
            for (int s = 0; s < 2; s++) begin
                hist[s].push_back(raw[s]);
                if (hist[s].size() > 32) void'(hist[s].pop_front());
                flip = 1'b1;
                for (int j = 0; j < DL; j++)
                    if (hist[s][hist[s].size() - 3 - j] == lvl[s]) flip = 1'b0;
                relp[s] = flip && lvl[s];
                if (flip) lvl[s] = !lvl[s];
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("led",  32'(led),  32'(m_led));
        check("chan", 32'(chan), 32'(m_chan));
        check("mode", 32'(mode), 32'(m_mode));
    endtask

    task automatic press(input int which, input int hold, input int gap);
        if (which == 0) sw1 = 1'b1; else sw2 = 1'b1;
        repeat (hold) cyc();
        sw1 = 1'b0;
        sw2 = 1'b0;
        repeat (gap) cyc();
    endtask

    initial begin
        int saved_chan;
        int which, hold, gap;
        bit found;

        // reset state
        rst_l = 1'b0;
        repeat (3) cyc();
        check("rst_led",  32'(led),  32'h0);
        check("rst_chan", 32'(chan), 32'h0);
        check("rst_mode", 32'(mode), 32'h0);
        rst_l = 1'b1;

        // first blink lands 16 clocks after reset release
        repeat (15) cyc();
        check("dark_before_first_tick", 32'(led), 32'h0);
        cyc();
        check("first_blink", 32'(led), 32'h1);
        repeat (45) cyc();

        // channel stepping with wrap
        for (int i = 0; i < 4; i++) begin
            press(0, 6, 10);
            check("ch_step", 32'(chan), 32'((i + 1) % NL));
            if (i == 2) repeat (35) cyc();
        end

        // 3-cycle glitch is filtered out
        sw2 = 1'b1;
        repeat (3) cyc();
        sw2 = 1'b0;
        repeat (12) cyc();
        check("glitch_mode", 32'(mode), 32'h0);

        // clean press into ALL
        press(1, 8, 10);
        check("mode_all", 32'(mode), 32'h1);
        repeat (40) cyc();

        // Switch_2 release landing on a tick, ALL -> CHASE
        sw2 = 1'b1;
        repeat (8) cyc();
        found = 1'b0;
        for (int k = 0; k < 2 * PERIOD && !found; k++) begin
            if ((ecnt + 7) % PERIOD == 0) found = 1'b1;
            else cyc();
        end
        check("align_tick", 32'(found), 32'h1);
        saved_chan = m_chan;
        sw2 = 1'b0;
        repeat (10) cyc();
        check("coinc_mode",  32'(mode), 32'h2);
        check("coinc_chan",  32'(chan), 32'(saved_chan));

        // Switch_1 ignored in CHASE; chase runs
        press(0, 6, 10);
        repeat (60) cyc();

        // CHASE -> SINGLE -> ALL -> CHASE
        press(1, 6, 10);
        check("back_single", 32'(mode), 32'h0);
        repeat (20) cyc();
        press(1, 6, 10);
        press(1, 6, 10);
        check("two_into_chase", 32'(mode), 32'h2);
        repeat (65) cyc();

        // randomized button activity, including glitches and simultaneous presses
        for (int n = 0; n < 30; n++) begin
            which = $urandom_range(0, 2);
            hold  = $urandom_range(1, 8);
            gap   = $urandom_range(1, 10);
            sw1 = (which != 1);
            sw2 = (which != 0);
            repeat (hold) cyc();
            sw1 = 1'b0;
            sw2 = 1'b0;
            repeat (gap) cyc();
        end
        repeat (20) cyc();

        // reset in the middle of a Switch_1 release debounce, CHASE, channel 2
        for (int k = 0; k < 3 && m_mode != 2; k++) press(1, 6, 10);
        check("reach_chase", 32'(mode), 32'h2);
        sw1 = 1'b1;
        repeat (8) cyc();
        found = 1'b0;
        for (int k = 0; k < 8 * PERIOD && !found; k++) begin
            if (m_chan == 2 && ecnt % PERIOD == 0) found = 1'b1;
            else cyc();
        end
        check("reach_chan2", 32'(found), 32'h1);
        sw1 = 1'b0;
        repeat (3) cyc();
        check("pre_rst_chan", 32'(chan), 32'h2);
        rst_l = 1'b0;
        cyc();
        check("mid_rst_mode", 32'(mode), 32'h0);
        check("mid_rst_chan", 32'(chan), 32'h0);
        check("mid_rst_led",  32'(led),  32'h0);
        rst_l = 1'b1;
        repeat (25) cyc();
        check("no_spurious_release", 32'(chan), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
